// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and address helpers for the instruction-cache refill path.
// The CRITICAL_WORD_FIRST_EN build option is consumed by icache_refill_ctrl.
package icache_pkg;

    localparam int ADDR_W   = 32;
    localparam int WORD_W   = 32;
    localparam int WORDS    = 4;
    localparam int LINE_W   = WORDS * WORD_W;
    localparam int OFFS_LSB = 2;
    localparam int IDX_LSB  = 4;
    localparam int TAG_LSB  = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_line_asm.sv
// Line assembly register: four word slots, one of which is written per accepted memory beat.
module icache_line_asm
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_slot,
    input  logic [WORD_W-1:0] wr_data,
    output logic [LINE_W-1:0] line
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
        end else if (wr_en) begin
            line[wr_slot*WORD_W +: WORD_W] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill: fetches four words from memory and presents the assembled line.
// Build option CRITICAL_WORD_FIRST_EN fetches the missed word first and adds crit_valid/crit_word.
//
// state | meaning
// IDLE  | waiting for miss_req
// REQ   | mem_req high, one word captured per mem_ack
// DONE  | fill_valid strobe, back to IDLE next cycle
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] dataLine
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic              crit_valid,
    output logic [WORD_W-1:0] crit_word
`endif
);

    state_t            state, state_nxt;
    logic [1:0]        beat, beat_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [1:0]        word_sel;
    logic              cap;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [1:0] offs, offs_nxt;
    assign word_sel = beat + offs;
`else
    assign word_sel = beat;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
            base  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            offs  <= '0;
`endif
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            base  <= base_nxt;
`ifdef CRITICAL_WORD_FIRST_EN
            offs  <= offs_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        base_nxt  = base;
        cap       = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
        offs_nxt  = offs;
`endif
        case (state)
            IDLE: begin
                if (miss_req) begin
                    state_nxt = REQ;
                    beat_nxt  = '0;
                    base_nxt  = line_base(miss_addr);
`ifdef CRITICAL_WORD_FIRST_EN
                    offs_nxt  = miss_addr[OFFS_LSB +: 2];
`endif
                end
            end
            REQ: begin
                // acks outside REQ never reach here, so stray acks cannot disturb the line
                if (mem_ack) begin
                    cap      = 1'b1;
                    beat_nxt = beat + 2'd1;
                    if (beat == 2'd3) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign mem_req    = (state == REQ);
    assign fill_valid = (state == DONE);
    assign fill_addr  = base;
    assign mem_addr   = base | ADDR_W'({word_sel, 2'b00});

    icache_line_asm u_line_asm (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap),
        .wr_slot (word_sel),
        .wr_data (mem_rdata),
        .line    (dataLine)
    );

`ifdef CRITICAL_WORD_FIRST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else begin
            crit_valid <= cap && (beat == 2'd0);
            if (cap && (beat == 2'd0)) begin
                crit_word <= mem_rdata;
            end
        end
    end
`endif

endmodule
